// File: rtl/vend_station_arbiter.sv
// Purpose: round-robin share of one vending machine among N_REQ stations, with stock precheck and delivery timeout.
// Latency: grant and machine drive one cycle after a request is seen in IDLE; done one cycle after delivery/timeout/sold-out.
// Backpressure: stations hold req until done; one transaction in flight, at least one IDLE cycle between transactions.
module vend_station_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 8,
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW     = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_item,
    input  logic [N_REQ-1:0] req_coin2,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             done,
    output logic [IDW-1:0]   done_id,
    output logic [1:0]       status,
    output logic             change_out,
    output logic             vm_item,
    output logic             vm_coin1,
    output logic             vm_coin2,
    input  logic             vm_deliver_tea,
    input  logic             vm_deliver_coffee,
    input  logic             vm_change,
    input  logic [1:0]       vm_tea_available,
    input  logic [1:0]       vm_coffee_available
);

    typedef enum logic [1:0] {IDLE, VEND, RESP} state_t;

    localparam logic [1:0] ST_SERVED  = 2'b00;
    localparam logic [1:0] ST_SOLDOUT = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_WRONG   = 2'b11;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             item_q, item_d;
    logic             coin2_q, coin2_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [1:0]       status_q, status_d;
    logic             change_q, change_d;
    logic             vm_item_q, vm_item_d;
    logic             vm_coin1_q, vm_coin1_d;
    logic             vm_coin2_q, vm_coin2_d;

    logic             win_vld;
    logic [IDW-1:0]   win_idx;
    logic             win_item;
    logic             win_coin2;
    logic             dlv_match;
    logic             dlv_other;

    // Round-robin winner: scan from the farthest slot back to ptr+1 so the nearest requester is the last assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[(int'(ptr_q) + i) % N_REQ]) begin
                win_vld = 1'b1;
                win_idx = IDW'((int'(ptr_q) + i) % N_REQ);
            end
        end
        win_item  = req_item[win_idx];
        win_coin2 = req_coin2[win_idx];
        dlv_match = item_q ? vm_deliver_tea    : vm_deliver_coffee;
        dlv_other = item_q ? vm_deliver_coffee : vm_deliver_tea;
    end

    // Next-state and registered-output computation; pulse-type outputs default low every cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        item_d     = item_q;
        coin2_d    = coin2_q;
        grant_d    = grant_q;
        done_d     = 1'b0;
        done_id_d  = '0;
        status_d   = ST_SERVED;
        change_d   = 1'b0;
        vm_item_d  = vm_item_q;
        vm_coin1_d = vm_coin1_q;
        vm_coin2_d = vm_coin2_q;
        case (state_q)
            IDLE: begin
                vm_item_d  = 1'b0;
                vm_coin1_d = 1'b0;
                vm_coin2_d = 1'b0;
                if (win_vld) begin
                    item_d           = win_item;
                    coin2_d          = win_coin2;
                    ptr_d            = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    if ((win_item ? vm_tea_available : vm_coffee_available) == 2'd0) begin
                        state_d   = RESP;
                        done_d    = 1'b1;
                        done_id_d = win_idx;
                        status_d  = ST_SOLDOUT;
                    end else begin
                        state_d    = VEND;
                        vm_item_d  = win_item;
                        vm_coin1_d = ~win_coin2;
                        vm_coin2_d = win_coin2;
                    end
                end
            end
            VEND: begin
                cnt_d = cnt_q + CW'(1);
                // A delivery on the last allowed cycle wins over the timeout.
                if (dlv_match || dlv_other || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d    = RESP;
                    done_d     = 1'b1;
                    done_id_d  = ptr_q;
                    vm_item_d  = 1'b0;
                    vm_coin1_d = 1'b0;
                    vm_coin2_d = 1'b0;
                    if (dlv_match) begin
                        status_d = ST_SERVED;
                        change_d = vm_change;
                    end else if (dlv_other) begin
                        status_d = ST_WRONG;
                        change_d = vm_change;
                    end else begin
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            RESP: begin
                state_d    = IDLE;
                grant_d    = '0;
                cnt_d      = '0;
                vm_item_d  = 1'b0;
                vm_coin1_d = 1'b0;
                vm_coin2_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears the machine drive and grant immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= IDW'(N_REQ - 1);
            cnt_q      <= '0;
            item_q     <= 1'b0;
            coin2_q    <= 1'b0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            status_q   <= 2'b00;
            change_q   <= 1'b0;
            vm_item_q  <= 1'b0;
            vm_coin1_q <= 1'b0;
            vm_coin2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            item_q     <= item_d;
            coin2_q    <= coin2_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            status_q   <= status_d;
            change_q   <= change_d;
            vm_item_q  <= vm_item_d;
            vm_coin1_q <= vm_coin1_d;
            vm_coin2_q <= vm_coin2_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_id    = done_id_q;
    assign status     = status_q;
    assign change_out = change_q;
    assign vm_item    = vm_item_q;
    assign vm_coin1   = vm_coin1_q;
    assign vm_coin2   = vm_coin2_q;

endmodule
